apb_param_completer: RTL and testbench



---
 rtl/apb_param_completer.sv | 163 ++++++++++++++++
 tb/tb_apb_param_completer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_param_completer.sv
// APB3/APB4 completer: NUM_REGS-word register file, fixed wait states plus s_wait stall, pslverr on out-of-range.
// Define APB_PSTRB_EN to add the APB4 pstrb byte-strobe input.
module apb_param_completer #(
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       ADDR_W      = 8,
    parameter int unsigned       NUM_REGS    = 16,
    parameter int unsigned       WAIT_STATES = 0,
    parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
`ifdef APB_PSTRB_EN
    input  logic [DATA_W/8-1:0] pstrb,
`endif
    input  logic              s_wait,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr
);

    localparam int unsigned STRB_W   = DATA_W / 8;
    localparam int unsigned ADDR_LSB = $clog2(STRB_W);
    localparam int unsigned IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned CNT_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [ADDR_W-1:0]   lat_addr, lat_addr_n;
    logic                lat_write, lat_write_n;
    logic [DATA_W-1:0]   lat_wdata, lat_wdata_n;
    logic [STRB_W-1:0]   lat_strb, lat_strb_n;
    logic [STRB_W-1:0]   strb_in;
    logic                pready_n, pslverr_n;
    logic [DATA_W-1:0]   prdata_n;
    logic                resp_load;
    logic                wr_en;
    logic [ADDR_W-1:0]   acc_addr;
    logic                acc_write;
    logic                acc_ok;
    logic                lat_ok;
    logic [DATA_W-1:0]   regs [NUM_REGS];

`ifdef APB_PSTRB_EN
    assign strb_in = pstrb;
`else
    assign strb_in = '1;
`endif

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (ADDR_W+1)'(a >> ADDR_LSB) < (ADDR_W+1)'(NUM_REGS);
    endfunction

    function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
        return IDX_W'(a >> ADDR_LSB);
    endfunction

    // The zero-wait path enters RESP straight from IDLE, so the response is
    // built from the live bus rather than the values being latched.
    assign acc_addr  = (state == ST_IDLE) ? paddr  : lat_addr;
    assign acc_write = (state == ST_IDLE) ? pwrite : lat_write;
    assign acc_ok    = in_range(acc_addr);
    assign lat_ok    = in_range(lat_addr);

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        lat_addr_n  = lat_addr;
        lat_write_n = lat_write;
        lat_wdata_n = lat_wdata;
        lat_strb_n  = lat_strb;
        pready_n    = 1'b0;
        pslverr_n   = 1'b0;
        prdata_n    = prdata;
        resp_load   = 1'b0;
        wr_en       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (psel && !penable) begin
                    lat_addr_n  = paddr;
                    lat_write_n = pwrite;
                    lat_wdata_n = pwdata;
                    lat_strb_n  = strb_in;
                    if (WAIT_STATES == 0 && !s_wait) begin
                        state_n   = ST_RESP;
                        resp_load = 1'b1;
                    end else begin
                        cnt_n   = CNT_W'(WAIT_STATES);
                        state_n = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!psel) begin
                    state_n = ST_IDLE;
                end else begin
                    if (cnt != '0) cnt_n = cnt - 1'b1;
                    if (cnt <= CNT_W'(1) && !s_wait) begin
                        state_n   = ST_RESP;
                        resp_load = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                state_n = ST_IDLE;
                if (psel && penable && lat_write && lat_ok) wr_en = 1'b1;
            end
            default: state_n = ST_IDLE;
        endcase

        if (resp_load) begin
            pready_n  = 1'b1;
            pslverr_n = !acc_ok;
            prdata_n  = (!acc_write && acc_ok) ? regs[idx_of(acc_addr)] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            lat_addr  <= '0;
            lat_write <= 1'b0;
            lat_wdata <= '0;
            lat_strb  <= '0;
            pready    <= 1'b0;
            pslverr   <= 1'b0;
            prdata    <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            lat_addr  <= lat_addr_n;
            lat_write <= lat_write_n;
            lat_wdata <= lat_wdata_n;
            lat_strb  <= lat_strb_n;
            pready    <= pready_n;
            pslverr   <= pslverr_n;
            prdata    <= prdata_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
        end else if (wr_en) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (lat_strb[b]) regs[idx_of(lat_addr)][8*b +: 8] <= lat_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_apb_param_completer.sv
// Directed bench for apb_param_completer: three instances (WAIT_STATES 0/2/3) on a shared bus,
// checked every cycle against a transfer-level register/timing model.
module tb_apb_param_completer;

    logic        clk;
    logic        rst;
    logic [2:0]  psel_v;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb_s;
    logic        s_wait;
    logic [31:0] prdata_o  [3];
    logic        pready_o  [3];
    logic        pslverr_o [3];

    logic        exp_rdy [3];
    logic        exp_err [3];
    logic [31:0] exp_rd  [3];
    logic        chk_zero;
    logic [31:0] model [3][16];

    int          checks = 0;
    int          errors = 0;
    int          lit_seq = 0;
    int          lit_done = 0;
    int          lit_inst = 0;
    logic [31:0] lit_exp = '0;

    function automatic int ws_of(input int i);
        return (i == 0) ? 0 : (i == 1) ? 2 : 3;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        apb_param_completer #(
            .DATA_W(32),
            .ADDR_W(8),
            .NUM_REGS(16),
            .WAIT_STATES((g == 0) ? 0 : (g == 1) ? 2 : 3),
            .RESET_VAL(32'h0)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .psel(psel_v[g]),
            .penable(penable),
            .pwrite(pwrite),
            .paddr(paddr),
            .pwdata(pwdata),
`ifdef APB_PSTRB_EN
            .pstrb(pstrb_s),
`endif
            .s_wait(s_wait),
            .prdata(prdata_o[g]),
            .pready(pready_o[g]),
            .pslverr(pslverr_o[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (pready_o[i] !== exp_rdy[i]) begin
                errors++;
                $display("FAIL pready inst%0d t=%0t got %b exp %b", i, $time, pready_o[i], exp_rdy[i]);
            end
            if (exp_rdy[i] || chk_zero) begin
                checks++;
                if (prdata_o[i] !== (chk_zero ? 32'h0 : exp_rd[i])) begin
                    errors++;
                    $display("FAIL prdata inst%0d t=%0t got %h exp %h", i, $time, prdata_o[i],
                             chk_zero ? 32'h0 : exp_rd[i]);
                end
                checks++;
                if (pslverr_o[i] !== (chk_zero ? 1'b0 : exp_err[i])) begin
                    errors++;
                    $display("FAIL pslverr inst%0d t=%0t got %b exp %b", i, $time, pslverr_o[i],
                             chk_zero ? 1'b0 : exp_err[i]);
                end
            end
        end
        if (lit_seq != lit_done && exp_rdy[lit_inst]) begin
            checks++;
            if (prdata_o[lit_inst] !== lit_exp) begin
                errors++;
                $display("FAIL literal#%0d inst%0d got %h exp %h", lit_seq, lit_inst, prdata_o[lit_inst], lit_exp);
            end
            lit_done = lit_seq;
        end
    end

    task automatic lit(input int inst, input logic [31:0] v);
        lit_inst = inst;
        lit_exp  = v;
        lit_seq++;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 3; i++)
            for (int r = 0; r < 16; r++) model[i][r] = 32'h0;
    endtask

    // One complete transfer; k = cycles s_wait is held high starting at setup.
    task automatic xfer(input int inst, input bit wr, input logic [7:0] addr,
                        input logic [31:0] data, input logic [3:0] strb, input int k);
        int         idx;
        int         low;
        bit         err;
        logic [3:0] eff;
        @(negedge clk);
        idx = int'(addr) / 4;
        err = (idx >= 16);
        low = (ws_of(inst) > k) ? ws_of(inst) : k;
        psel_v       = '0;
        psel_v[inst] = 1'b1;
        penable      = 1'b0;
        pwrite       = wr;
        paddr        = addr;
        pwdata       = data;
        pstrb_s      = strb;
        s_wait       = (k > 0);
        exp_err[inst] = err;
        exp_rd[inst]  = 32'h0;
        if (!wr && !err) exp_rd[inst] = model[inst][idx];
        exp_rdy[inst] = (low == 0);
        for (int j = 1; j <= low + 1; j++) begin
            @(negedge clk);
            penable       = 1'b1;
            pwdata        = ~data;
            pstrb_s       = ~strb;
            s_wait        = (j < k);
            exp_rdy[inst] = (j == low);
        end
`ifdef APB_PSTRB_EN
        eff = strb;
`else
        eff = 4'hf;
`endif
        if (wr && !err)
            for (int b = 0; b < 4; b++)
                if (eff[b]) model[inst][idx][8*b +: 8] = data[8*b +: 8];
    endtask

    task automatic idle();
        @(negedge clk);
        psel_v  = '0;
        penable = 1'b0;
        s_wait  = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        psel_v   = '0;
        penable  = 1'b0;
        pwrite   = 1'b0;
        paddr    = '0;
        pwdata   = '0;
        pstrb_s  = '0;
        s_wait   = 1'b0;
        chk_zero = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_rdy[i] = 1'b0;
            exp_err[i] = 1'b0;
            exp_rd[i]  = 32'h0;
        end
        clear_model();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_zero = 1'b0;

        // Reset contents, zero-wait, back-to-back reads of every index
        for (int a = 0; a < 16; a++) xfer(0, 1'b0, 8'(a * 4), 32'h0, 4'hf, 0);
        idle();

        // Three fixed wait states on write and read
        xfer(2, 1'b1, 8'h08, 32'hA5A5_1234, 4'hf, 0);
        lit(2, 32'hA5A5_1234);
        xfer(2, 1'b0, 8'h08, 32'h0, 4'hf, 0);

        // Out-of-range write is dropped, out-of-range read errors
        xfer(0, 1'b1, 8'h00, 32'h0BAD_F00D, 4'hf, 0);
        xfer(0, 1'b1, 8'h40, 32'hDEAD_BEEF, 4'hf, 0);
        lit(0, 32'h0BAD_F00D);
        xfer(0, 1'b0, 8'h00, 32'h0, 4'hf, 0);
        xfer(0, 1'b0, 8'h40, 32'h0, 4'hf, 0);
        xfer(0, 1'b0, 8'hFC, 32'h0, 4'hf, 0);

        // Read immediately after write to the same register, low address bits ignored
        xfer(0, 1'b1, 8'h05, 32'hCAFE_0004, 4'hf, 0);
        lit(0, 32'hCAFE_0004);
        xfer(0, 1'b0, 8'h07, 32'h0, 4'hf, 0);

        // s_wait longer and shorter than WAIT_STATES
        xfer(1, 1'b1, 8'h10, 32'h5555_AAAA, 4'hf, 5);
        lit(1, 32'h5555_AAAA);
        xfer(1, 1'b0, 8'h10, 32'h0, 4'hf, 0);
        xfer(1, 1'b0, 8'h10, 32'h0, 4'hf, 1);
        xfer(0, 1'b0, 8'h00, 32'h0, 4'hf, 3);
        xfer(2, 1'b0, 8'h08, 32'h0, 4'hf, 6);

        // Abort: psel dropped in WAIT, write must not land
        xfer(1, 1'b1, 8'h14, 32'h600D_CAFE, 4'hf, 0);
        @(negedge clk);
        psel_v     = 3'b010;
        penable    = 1'b0;
        pwrite     = 1'b1;
        paddr      = 8'h14;
        pwdata     = 32'h0000_0077;
        pstrb_s    = 4'hf;
        exp_rdy[1] = 1'b0;
        @(negedge clk);
        psel_v  = '0;
        penable = 1'b0;
        lit(1, 32'h600D_CAFE);
        xfer(1, 1'b0, 8'h14, 32'h0, 4'hf, 0);

        // Reset during a write in WAIT
        xfer(1, 1'b1, 8'h0C, 32'h1234_5678, 4'hf, 0);
        @(negedge clk);
        psel_v     = 3'b010;
        penable    = 1'b0;
        pwrite     = 1'b1;
        paddr      = 8'h0C;
        pwdata     = 32'hFFFF_0000;
        exp_rdy[1] = 1'b0;
        @(negedge clk);
        penable  = 1'b1;
        rst      = 1'b1;
        chk_zero = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        psel_v  = '0;
        penable = 1'b0;
        clear_model();
        @(negedge clk);
        chk_zero = 1'b0;
        lit(1, 32'h0);
        xfer(1, 1'b0, 8'h0C, 32'h0, 4'hf, 0);
        xfer(2, 1'b0, 8'h08, 32'h0, 4'hf, 0);

`ifdef APB_PSTRB_EN
        // Byte strobes, including an all-zero strobe write
        xfer(0, 1'b1, 8'h04, 32'h1122_3344, 4'hf, 0);
        xfer(0, 1'b1, 8'h04, 32'hAABB_CCDD, 4'b0101, 0);
        lit(0, 32'h11BB_33DD);
        xfer(0, 1'b0, 8'h04, 32'h0, 4'h0, 0);
        xfer(0, 1'b1, 8'h04, 32'h9999_9999, 4'h0, 0);
        lit(0, 32'h11BB_33DD);
        xfer(0, 1'b0, 8'h04, 32'h0, 4'hf, 0);
`endif

        idle();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
